// File: rtl/decode_queue.sv
//==============================================================================
// Module      : decode_queue
// Description : Small in-order queue of decoded instructions. Each accepted
//               instruction is classified at push time (class, memory access
//               size/signedness, exception code) and stored alongside its pc
//               and instruction word. The head entry is presented on out_*.
// Ports       : clk, reset (sync, active-high), flush
//               in_valid/in_ready/in_pc/in_instr     - fetch side
//               out_valid/out_ready/out_pc/out_instr - consumer side
//               out_class/out_mem_size/out_mem_signed/out_exc_code - decode
//               count                                - entries held
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module decode_queue #(
  parameter int DEPTH  = 4,
  parameter int EXT_EN = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [2:0]                 out_class,
  output logic [1:0]                 out_mem_size,
  output logic                       out_mem_signed,
  output logic [4:0]                 out_exc_code,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] c_CLS_RTYPE  = 3'd0;
  localparam logic [2:0] c_CLS_BRANCH = 3'd1;
  localparam logic [2:0] c_CLS_IMM    = 3'd2;
  localparam logic [2:0] c_CLS_LOAD   = 3'd3;
  localparam logic [2:0] c_CLS_STORE  = 3'd4;
  localparam logic [2:0] c_CLS_EXC    = 3'd7;

  localparam logic [1:0] c_SZ_BYTE = 2'd0;
  localparam logic [1:0] c_SZ_HALF = 2'd1;
  localparam logic [1:0] c_SZ_WORD = 2'd2;

  localparam logic [4:0] c_EXC_ADEL = 5'd4;
  localparam logic [4:0] c_EXC_RI   = 5'd10;

  localparam logic c_EXT = (EXT_EN != 0);

  // Storage
  logic [31:0] r_pc_mem    [DEPTH];
  logic [31:0] r_instr_mem [DEPTH];
  logic [2:0]  r_class_mem [DEPTH];
  logic [1:0]  r_size_mem  [DEPTH];
  logic        r_sign_mem  [DEPTH];
  logic [4:0]  r_exc_mem   [DEPTH];

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic       w_push;
  logic       w_pop;
  logic [5:0] w_op;
  logic [2:0] w_class;
  logic [1:0] w_size;
  logic       w_sign;
  logic [4:0] w_exc;

  assign in_ready  = (r_count < CW'(DEPTH)) && !reset;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;
  assign count     = r_count;

  assign out_pc         = r_pc_mem[r_rptr];
  assign out_instr      = r_instr_mem[r_rptr];
  assign out_class      = r_class_mem[r_rptr];
  assign out_mem_size   = r_size_mem[r_rptr];
  assign out_mem_signed = r_sign_mem[r_rptr];
  assign out_exc_code   = r_exc_mem[r_rptr];

  assign w_op = in_instr[31:26];

  // Decode of the incoming instruction. A misaligned pc wins over any
  // opcode decode, including the reserved-instruction fallback.
  always_comb begin
    w_class = c_CLS_EXC;
    w_size  = c_SZ_BYTE;
    w_sign  = 1'b0;
    w_exc   = c_EXC_RI;
    case (w_op)
      6'h00: begin w_class = c_CLS_RTYPE; w_exc = '0; end
      6'h02, 6'h03, 6'h04, 6'h05: begin w_class = c_CLS_BRANCH; w_exc = '0; end
      6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        w_class = c_CLS_IMM; w_exc = '0;
      end
      6'h23: begin w_class = c_CLS_LOAD; w_size = c_SZ_WORD; w_sign = 1'b1; w_exc = '0; end
      6'h2B: begin w_class = c_CLS_STORE; w_size = c_SZ_WORD; w_exc = '0; end
      6'h01, 6'h06, 6'h07: if (c_EXT) begin w_class = c_CLS_BRANCH; w_exc = '0; end
      6'h20: if (c_EXT) begin w_class = c_CLS_LOAD; w_size = c_SZ_BYTE; w_sign = 1'b1; w_exc = '0; end
      6'h21: if (c_EXT) begin w_class = c_CLS_LOAD; w_size = c_SZ_HALF; w_sign = 1'b1; w_exc = '0; end
      6'h24: if (c_EXT) begin w_class = c_CLS_LOAD; w_size = c_SZ_BYTE; w_exc = '0; end
      6'h25: if (c_EXT) begin w_class = c_CLS_LOAD; w_size = c_SZ_HALF; w_exc = '0; end
      6'h28: if (c_EXT) begin w_class = c_CLS_STORE; w_size = c_SZ_BYTE; w_exc = '0; end
      6'h29: if (c_EXT) begin w_class = c_CLS_STORE; w_size = c_SZ_HALF; w_exc = '0; end
      default: ;
    endcase
    if (in_pc[1:0] != 2'b00) begin
      w_class = c_CLS_EXC;
      w_size  = c_SZ_BYTE;
      w_sign  = 1'b0;
      w_exc   = c_EXC_ADEL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
        r_class_mem[i] <= '0;
        r_size_mem[i]  <= '0;
        r_sign_mem[i]  <= 1'b0;
        r_exc_mem[i]   <= '0;
      end
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wptr]    <= in_pc;
        r_instr_mem[r_wptr] <= in_instr;
        r_class_mem[r_wptr] <= w_class;
        r_size_mem[r_wptr]  <= w_size;
        r_sign_mem[r_wptr]  <= w_sign;
        r_exc_mem[r_wptr]   <= w_exc;
        r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_queue.sv
//==============================================================================
// Module      : tb_decode_queue
// Description : Self-checking bench for decode_queue. Two instances (extended
//               and base opcode sets) share one stimulus stream and are
//               compared against a queue-based reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_decode_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        in_ready_x,  in_ready_b;
  logic        out_valid_x, out_valid_b;
  logic [31:0] out_pc_x,    out_pc_b;
  logic [31:0] out_instr_x, out_instr_b;
  logic [2:0]  out_class_x, out_class_b;
  logic [1:0]  out_size_x,  out_size_b;
  logic        out_sign_x,  out_sign_b;
  logic [4:0]  out_exc_x,   out_exc_b;
  logic [2:0]  count_x,     count_b;

  decode_queue #(.DEPTH(DEPTH), .EXT_EN(1)) u_dut_ext (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_x), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid_x), .out_ready(out_ready), .out_pc(out_pc_x),
    .out_instr(out_instr_x), .out_class(out_class_x), .out_mem_size(out_size_x),
    .out_mem_signed(out_sign_x), .out_exc_code(out_exc_x), .count(count_x)
  );

  decode_queue #(.DEPTH(DEPTH), .EXT_EN(0)) u_dut_base (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b),
    .out_instr(out_instr_b), .out_class(out_class_b), .out_mem_size(out_size_b),
    .out_mem_signed(out_sign_b), .out_exc_code(out_exc_b), .count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: in-order list of accepted (pc, instr) pairs.
  logic [31:0] m_pc[$];
  logic [31:0] m_instr[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected decode as {class[2:0], size[1:0], signed, exc[4:0]}.
  function automatic logic [10:0] ref_decode(input logic [31:0] pc, input logic [31:0] instr,
                                            input bit ext);
    int op;
    op = int'(instr[31:26]);
    if (pc[1:0] != 2'b00) return {3'd7, 2'd0, 1'b0, 5'd4};
    if (op == 0)                 return {3'd0, 2'd0, 1'b0, 5'd0};
    if (op >= 2 && op <= 5)      return {3'd1, 2'd0, 1'b0, 5'd0};
    if (op >= 9 && op <= 15)     return {3'd2, 2'd0, 1'b0, 5'd0};
    if (op == 'h23)              return {3'd3, 2'd2, 1'b1, 5'd0};
    if (op == 'h2B)              return {3'd4, 2'd2, 1'b0, 5'd0};
    if (ext) begin
      if (op == 1 || op == 6 || op == 7) return {3'd1, 2'd0, 1'b0, 5'd0};
      if (op == 'h20) return {3'd3, 2'd0, 1'b1, 5'd0};
      if (op == 'h21) return {3'd3, 2'd1, 1'b1, 5'd0};
      if (op == 'h24) return {3'd3, 2'd0, 1'b0, 5'd0};
      if (op == 'h25) return {3'd3, 2'd1, 1'b0, 5'd0};
      if (op == 'h28) return {3'd4, 2'd0, 1'b0, 5'd0};
      if (op == 'h29) return {3'd4, 2'd1, 1'b0, 5'd0};
    end
    return {3'd7, 2'd0, 1'b0, 5'd10};
  endfunction

  task automatic compare_all();
    logic [10:0] dx, db;
    int n;
    n = m_pc.size();
    check("ext.count",     32'(count_x),     32'(n));
    check("base.count",    32'(count_b),     32'(n));
    check("ext.out_valid", 32'(out_valid_x), 32'(n != 0));
    check("base.out_valid",32'(out_valid_b), 32'(n != 0));
    check("ext.in_ready",  32'(in_ready_x),  32'(n < DEPTH && !reset));
    check("base.in_ready", 32'(in_ready_b),  32'(n < DEPTH && !reset));
    if (n != 0) begin
      dx = ref_decode(m_pc[0], m_instr[0], 1'b1);
      db = ref_decode(m_pc[0], m_instr[0], 1'b0);
      check("ext.out_pc",      out_pc_x,          m_pc[0]);
      check("ext.out_instr",   out_instr_x,       m_instr[0]);
      check("ext.out_class",   32'(out_class_x),  32'(dx[10:8]));
      check("ext.out_size",    32'(out_size_x),   32'(dx[7:6]));
      check("ext.out_signed",  32'(out_sign_x),   32'(dx[5]));
      check("ext.out_exc",     32'(out_exc_x),    32'(dx[4:0]));
      check("base.out_pc",     out_pc_b,          m_pc[0]);
      check("base.out_instr",  out_instr_b,       m_instr[0]);
      check("base.out_class",  32'(out_class_b),  32'(db[10:8]));
      check("base.out_size",   32'(out_size_b),   32'(db[7:6]));
      check("base.out_signed", 32'(out_sign_b),   32'(db[5]));
      check("base.out_exc",    32'(out_exc_b),    32'(db[4:0]));
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                      input bit rdy, input bit fl, input bit rst);
    bit do_push, do_pop;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = rdy;
    flush     = fl;
    reset     = rst;
    do_push = v && (m_pc.size() < DEPTH) && !fl && !rst;
    do_pop  = (m_pc.size() != 0) && rdy && !fl && !rst;
    @(posedge clk);
    if (rst || fl) begin
      m_pc.delete();
      m_instr.delete();
    end else begin
      if (do_pop) begin
        void'(m_pc.pop_front());
        void'(m_instr.pop_front());
      end
      if (do_push) begin
        m_pc.push_back(pc);
        m_instr.push_back(instr);
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [14];
    logic [31:0] w;
    ops = '{6'h00, 6'h02, 6'h05, 6'h09, 6'h0F, 6'h23, 6'h2B,
            6'h01, 6'h07, 6'h20, 6'h21, 6'h24, 6'h29, 6'h3F};
    w = $urandom;
    if ($urandom_range(0, 3) != 0) w[31:26] = ops[$urandom_range(0, 13)];
    return w;
  endfunction

  initial begin
    in_valid = 0; in_pc = 0; in_instr = 0; out_ready = 0; flush = 0; reset = 1;
    @(negedge clk);

    // Reset and post-reset state
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check("rst.out_pc",    out_pc_x,           32'h0);
    check("rst.out_instr", out_instr_x,        32'h0);
    check("rst.out_class", 32'(out_class_x),   32'h0);
    check("rst.out_exc",   32'(out_exc_b),     32'h0);

    // LW into empty queue
    step(1, 32'hBFC00000, 32'h8C820004, 0, 0, 0);
    check("lw.class", 32'(out_class_x), 32'd3);
    check("lw.size",  32'(out_size_x),  32'd2);
    check("lw.sign",  32'(out_sign_x),  32'd1);
    check("lw.count", 32'(count_x),     32'd1);

    // Fill: 4 more offers with no pop (one already queued -> full after 3)
    for (int i = 0; i < 4; i++) step(1, 32'h1000 + 32'(i*4), 32'h24420001 + 32'(i), 0, 0, 0);
    check("full.count",    32'(count_x),    32'd4);
    check("full.in_ready", 32'(in_ready_x), 32'd0);
    // Pop + push while full: push refused
    step(1, 32'h2000, 32'h00000020, 1, 0, 0);
    check("fullpp.count",  32'(count_x),    32'd3);

    // Drain, then LB and misaligned ADDIU
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
    step(1, 32'h3000, 32'h80A40000, 0, 0, 0);
    check("lb.ext.class",  32'(out_class_x), 32'd3);
    check("lb.ext.size",   32'(out_size_x),  32'd0);
    check("lb.ext.sign",   32'(out_sign_x),  32'd1);
    check("lb.base.class", 32'(out_class_b), 32'd7);
    check("lb.base.exc",   32'(out_exc_b),   32'd10);
    step(1, 32'hBFC00002, 32'h24420001, 1, 0, 0);
    check("adel.class", 32'(out_class_x), 32'd7);
    check("adel.exc",   32'(out_exc_x),   32'd4);

    // Queue of 3, then flush with valid/ready both high
    step(1, 32'h4000, 32'h00000000, 0, 0, 0);
    step(1, 32'h4004, 32'h10000000, 0, 0, 0);
    check("pre.flush.count", 32'(count_x), 32'd3);
    step(1, 32'h4008, 32'h8C000000, 1, 1, 0);
    check("flush.count", 32'(count_x),     32'd0);
    check("flush.valid", 32'(out_valid_b), 32'd0);

    // Stream of 10 with continuous pop
    for (int i = 0; i < 10; i++) step(1, 32'h5000 + 32'(i*4), rand_instr(), 1, 0, 0);
    check("stream.count", 32'(count_x), 32'd1);
    step(0, 0, 0, 1, 0, 0);

    // Randomized traffic including occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc;
      pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      step($urandom_range(0, 3) != 0, pc, rand_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
